// File: rtl/lisa_fops_pkg.sv
// lisa_fops_pkg: shared types and bf16 defaults for the LISA float ops unit.
// Rev 1.0
`default_nettype none

package lisa_fops_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC = 2'd0,
    RND_RNE   = 2'd1,
    RND_FLOOR = 2'd2,
    RND_CEIL  = 2'd3
  } rnd_mode_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_OUT   = 2'd3;

  // Operand class decided once at acceptance; only K_NORM uses the shifter.
  typedef enum logic [1:0] {
    K_NORM = 2'd0,
    K_ZERO = 2'd1,
    K_NAN  = 2'd2,
    K_SAT  = 2'd3
  } kind_t;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

endpackage

`default_nettype wire

// File: rtl/lisa_fp_round.sv
// lisa_fp_round: combinational rounding increment on a magnitude with guard/sticky.
// Rev 1.0
`default_nettype none

module lisa_fp_round
  import lisa_fops_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] mag,
  input  logic         g,
  input  logic         s,
  input  logic         sign,
  input  logic [1:0]   mode,
  output logic [W-1:0] m
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (rnd_mode_t'(mode))
      RND_TRUNC: inc = 1'b0;
      RND_RNE:   inc = g & (s | mag[0]);
      RND_FLOOR: inc = sign & (g | s);
      RND_CEIL:  inc = !sign & (g | s);
    endcase
  end

  assign m = mag + W'(inc);

endmodule

`default_nettype wire

// File: rtl/lisa_fp2i_seq.sv
// lisa_fp2i_seq: multi-cycle float-to-integer converter with iterative shifter.
// Rev 1.0
`default_nettype none

module lisa_fp2i_seq
  import lisa_fops_pkg::*;
#(
  parameter int EXP_W      = BF16_EXP_W,
  parameter int MAN_W      = BF16_MAN_W,
  parameter int INT_W      = 16,
  parameter int SHIFT_STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   f_i,
  input  logic                   i_signed,
  input  logic [1:0]             rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       i_o,
  output logic                   flg_invalid,
  output logic                   flg_inexact
);

  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int BW    = INT_W + 2;
  localparam int MAXSH = (MAN_W + 2 > INT_W - MAN_W) ? MAN_W + 2 : INT_W - MAN_W;
  localparam int CNT_W = $clog2(MAXSH + 1);
  localparam int EW    = ((EXP_W > $clog2(INT_W + 2)) ? EXP_W : $clog2(INT_W + 2)) + 2;

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_OVF  = EW'(INT_W + 1);
  localparam logic signed [EW-1:0] E_MAN  = EW'(MAN_W);
  localparam logic signed [EW-1:0] E_LOW  = -EW'(2);

  localparam logic [INT_W-1:0] SMAX    = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SMIN    = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   LIM_POS = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   LIM_NEG = {2'b01, {(INT_W-1){1'b0}}};

  state_t             state;
  logic               sign_q;
  logic               sgn_q;
  logic [1:0]         mode_q;
  kind_t              kind_q;
  logic [BW-1:0]      body;     // {integer magnitude, guard}
  logic               sticky;
  logic [CNT_W-1:0]   cnt;
  logic               left_q;

  logic               in_sign;
  logic [EXP_W-1:0]   in_exp;
  logic [MAN_W-1:0]   in_man;
  logic signed [EW-1:0] e;

  kind_t              dec_kind;
  logic               dec_left;
  logic [CNT_W-1:0]   dec_cnt;
  logic [BW-1:0]      dec_body;

  logic [CNT_W-1:0]   step;
  logic [BW-1:0]      shift_body;
  logic               shift_sticky;

  logic [INT_W:0]     m;
  logic [INT_W-1:0]   res;
  logic               res_inv;
  logic               res_inx;

  assign {in_sign, in_exp, in_man} = f_i;
  assign e = signed'(EW'(in_exp)) - E_BIAS;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);

  always_comb begin
    dec_kind = K_NORM;
    dec_left = 1'b0;
    dec_cnt  = '0;
    dec_body = '0;
    dec_body[MAN_W+1:0] = {1'b1, in_man, 1'b0};
    if (in_exp == '0) begin
      dec_kind = K_ZERO;
    end else if (&in_exp) begin
      dec_kind = (in_man != '0) ? K_NAN : K_SAT;
    end else if (e >= E_OVF) begin
      dec_kind = K_SAT;
    end else if (e >= E_MAN) begin
      dec_left = 1'b1;
      dec_cnt  = CNT_W'(e - E_MAN);
    end else if (e < E_LOW) begin
      // Past MAN_W+2 every bit already sits in sticky.
      dec_cnt = CNT_W'(MAN_W + 2);
    end else begin
      dec_cnt = CNT_W'(E_MAN - e);
    end
  end

  always_comb begin
    step = (cnt > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : cnt;
    if (left_q) begin
      shift_body   = body << step;
      shift_sticky = sticky;
    end else begin
      shift_body   = body >> step;
      shift_sticky = sticky | (|(body & ((BW'(1) << step) - BW'(1))));
    end
  end

  lisa_fp_round #(.W(INT_W + 1)) u_round (
    .mag  (body[BW-1:1]),
    .g    (body[0]),
    .s    (sticky),
    .sign (sign_q),
    .mode (mode_q),
    .m    (m)
  );

  always_comb begin
    res     = '0;
    res_inv = 1'b0;
    res_inx = 1'b0;
    case (kind_q)
      K_ZERO: res = '0;
      K_NAN: begin
        res     = sgn_q ? SMAX : '1;
        res_inv = 1'b1;
      end
      K_SAT: begin
        res_inv = 1'b1;
        if (sgn_q) res = sign_q ? SMIN : SMAX;
        else       res = sign_q ? '0 : '1;
      end
      default: begin
        if (sgn_q) begin
          if (m > (sign_q ? LIM_NEG : LIM_POS)) begin
            res_inv = 1'b1;
            res     = sign_q ? SMIN : SMAX;
          end else begin
            res = sign_q ? (-m[INT_W-1:0]) : m[INT_W-1:0];
          end
        end else if (sign_q) begin
          res_inv = (m != '0);
        end else if (m[INT_W]) begin
          res_inv = 1'b1;
          res     = '1;
        end else begin
          res = m[INT_W-1:0];
        end
        res_inx = (body[0] | sticky) & !res_inv;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sign_q      <= 1'b0;
      sgn_q       <= 1'b0;
      mode_q      <= '0;
      kind_q      <= K_ZERO;
      body        <= '0;
      sticky      <= 1'b0;
      cnt         <= '0;
      left_q      <= 1'b0;
      i_o         <= '0;
      flg_invalid <= 1'b0;
      flg_inexact <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            sgn_q  <= i_signed;
            mode_q <= rnd_mode;
            kind_q <= dec_kind;
            body   <= dec_body;
            sticky <= 1'b0;
            cnt    <= dec_cnt;
            left_q <= dec_left;
            state  <= (dec_kind != K_NORM || dec_cnt == '0) ? ST_ROUND : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          body   <= shift_body;
          sticky <= shift_sticky;
          cnt    <= cnt - step;
          if (cnt == step) state <= ST_ROUND;
        end
        ST_ROUND: begin
          i_o         <= res;
          flg_invalid <= res_inv;
          flg_inexact <= res_inx;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lisa_fp2i_seq.sv
// tb_lisa_fp2i_seq: directed-vector bench for the bf16 -> int16 converter.
// Rev 1.0
`default_nettype none

module tb_lisa_fp2i_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] f_i;
  logic        i_signed;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] i_o;
  logic        flg_invalid;
  logic        flg_inexact;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] TRUNC = 2'd0, RNE = 2'd1, FLOOR = 2'd2, CEIL = 2'd3;

  always #5 clk = ~clk;

  lisa_fp2i_seq #(.EXP_W(8), .MAN_W(7), .INT_W(16), .SHIFT_STEP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .f_i         (f_i),
    .i_signed    (i_signed),
    .rnd_mode    (rnd_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .i_o         (i_o),
    .flg_invalid (flg_invalid),
    .flg_inexact (flg_inexact)
  );

  // One conversion with out_ready held high; res = {i_o, invalid, inexact},
  // lat = rising edges after the accepting edge until out_valid is seen.
  task automatic convert(input logic [15:0] f, input logic sgn, input logic [1:0] mode,
                         output logic [17:0] res, output int lat);
    int guard;
    @(negedge clk);
    f_i = f; i_signed = sgn; rnd_mode = mode; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    res = 'x;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL timeout f=%h: out_valid=%b required 1", f, out_valid);
      lat = -1;
    end else begin
      res = {i_o, flg_invalid, flg_inexact};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    f_i = '0; i_signed = 1'b0; rnd_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, i_o, flg_invalid, flg_inexact} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b i_o=%h inv=%b inx=%b required 1 0 0000 0 0",
               in_ready, out_valid, i_o, flg_invalid, flg_inexact);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rounding();
    logic [15:0] fv [9] = '{16'h4060, 16'h4060, 16'h4060, 16'h4060, 16'h4020,
                            16'hBFC0, 16'hBFC0, 16'hBFC0, 16'hBFC0};
    logic [1:0]  mv [9] = '{RNE, TRUNC, FLOOR, CEIL, RNE, RNE, TRUNC, FLOOR, CEIL};
    logic [17:0] ev [9] = '{{16'h0004, 2'b01}, {16'h0003, 2'b01}, {16'h0003, 2'b01},
                            {16'h0004, 2'b01}, {16'h0002, 2'b01}, {16'hFFFE, 2'b01},
                            {16'hFFFF, 2'b01}, {16'hFFFE, 2'b01}, {16'hFFFF, 2'b01}};
    logic [17:0] r;
    int lat;
    for (int i = 0; i < 9; i++) begin
      convert(fv[i], 1'b1, mv[i], r, lat);
      checks++;
      if (r !== ev[i]) begin
        errors++;
        $display("FAIL round[%0d] f=%h mode=%0d: got %h required %h", i, fv[i], mv[i], r, ev[i]);
      end
      // 3.5 needs 6 right shifts -> n=2; out_valid in cycle k+4, i.e. 3 edges after acceptance
      if (i == 0) begin
        checks++;
        if (lat != 3) begin
          errors++;
          $display("FAIL latency 3.5: got %0d edges required 3", lat);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] fv [7] = '{16'h4700, 16'hC700, 16'h477F, 16'h4780, 16'h4780, 16'hC800, 16'h4300};
    logic        sv [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [17:0] ev [7] = '{{16'h7FFF, 2'b10}, {16'h8000, 2'b00}, {16'hFF00, 2'b00},
                            {16'h7FFF, 2'b10}, {16'hFFFF, 2'b10}, {16'h8000, 2'b10},
                            {16'h0080, 2'b00}};
    int          lv [7] = '{3, 3, 3, 4, 4, 1, 1};
    logic [17:0] r;
    int lat;
    for (int i = 0; i < 7; i++) begin
      convert(fv[i], sv[i], RNE, r, lat);
      checks++;
      if (r !== ev[i]) begin
        errors++;
        $display("FAIL sat[%0d] f=%h signed=%b: got %h required %h", i, fv[i], sv[i], r, ev[i]);
      end
      if (i >= 3) begin
        checks++;
        if (lat != lv[i]) begin
          errors++;
          $display("FAIL sat_latency[%0d] f=%h: got %0d edges required %0d", i, fv[i], lat, lv[i]);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [15:0] fv [6] = '{16'h7FC0, 16'hFF80, 16'h0001, 16'h8000, 16'h7FC0, 16'h7F80};
    logic        sv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [17:0] ev [6] = '{{16'h7FFF, 2'b10}, {16'h8000, 2'b10}, {16'h0000, 2'b00},
                            {16'h0000, 2'b00}, {16'hFFFF, 2'b10}, {16'hFFFF, 2'b10}};
    logic [17:0] r;
    int lat;
    for (int i = 0; i < 6; i++) begin
      convert(fv[i], sv[i], CEIL, r, lat);
      checks++;
      if (r !== ev[i]) begin
        errors++;
        $display("FAIL special[%0d] f=%h signed=%b: got %h required %h", i, fv[i], sv[i], r, ev[i]);
      end
      if (i == 0) begin
        checks++;
        if (lat != 1) begin
          errors++;
          $display("FAIL nan_latency: got %0d edges required 1", lat);
        end
      end
    end
  endtask

  task automatic test_unsigned_negative();
    logic [15:0] fv [4] = '{16'hBE80, 16'hBE80, 16'hBE80, 16'hBF80};
    logic [1:0]  mv [4] = '{RNE, CEIL, FLOOR, RNE};
    logic [17:0] ev [4] = '{{16'h0000, 2'b01}, {16'h0000, 2'b01}, {16'h0000, 2'b10},
                            {16'h0000, 2'b10}};
    logic [17:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      convert(fv[i], 1'b0, mv[i], r, lat);
      checks++;
      if (r !== ev[i]) begin
        errors++;
        $display("FAIL uneg[%0d] f=%h mode=%0d: got %h required %h", i, fv[i], mv[i], r, ev[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    f_i = 16'h4060; i_signed = 1'b1; rnd_mode = RNE; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, i_o, flg_invalid, flg_inexact} !== {1'b1, 1'b0, 16'h0004, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL hold[%0d]: vld=%b rdy=%b i_o=%h inv=%b inx=%b required 1 0 0004 0 1",
                 c, out_valid, in_ready, i_o, flg_invalid, flg_inexact);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [17:0] r;
    int lat;
    int seen;
    @(negedge clk);
    f_i = 16'h4700; i_signed = 1'b1; rnd_mode = RNE; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL discarded: out_valid seen %0d cycles required 0", seen);
    end
    convert(16'h3F80, 1'b1, TRUNC, r, lat);
    checks++;
    if (r !== {16'h0001, 2'b00}) begin
      errors++;
      $display("FAIL after_reset 1.0: got %h required %h", r, {16'h0001, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_special();
    test_unsigned_negative();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
